// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter sharing the single-ported SOPC memory between instruction fetch (m0)
// and load/store (m1), with bounded fetch starvation and a slave response timeout.
module mem_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 16,
    parameter int MAX_STARVE = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic [ADDR_W-1:0]     m0_addr,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic                  m0_ack,
    output logic                  m0_err,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_sel,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic                  m1_ack,
    output logic                  m1_err,

    output logic                  slv_stb,
    output logic                  slv_we,
    output logic [ADDR_W-1:0]     slv_addr,
    output logic [DATA_W-1:0]     slv_wdata,
    output logic [DATA_W/8-1:0]   slv_sel,
    input  logic                  slv_ack,
    input  logic [DATA_W-1:0]     slv_rdata,

    output logic                  stall_if,
    output logic                  stall_mem
);

    localparam int SEL_W = DATA_W / 8;
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SW    = (MAX_STARVE > 0) ? $clog2(MAX_STARVE + 1) : 1;

    localparam logic [TW-1:0] TMO_LAST   = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           tmo_hit;
    logic           m0_forced;

    assign tmo_hit   = (TIMEOUT != 0) && (tmo_q == TMO_LAST);
    assign m0_forced = m0_req && (starve_q == STARVE_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            tmo_q    <= tmo_d;
        end
    end

    // Arbitration happens only in IDLE, so every access is followed by one idle bubble.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        tmo_d    = tmo_q;
        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (m1_req && !m0_forced) begin
                    state_d = GNT1;
                    if (m0_req) begin
                        starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);
                    end else begin
                        starve_d = '0;
                    end
                end else if (m0_req) begin
                    state_d  = GNT0;
                    starve_d = '0;
                end else begin
                    starve_d = '0;
                end
            end
            GNT0, GNT1: begin
                if (slv_ack || tmo_hit) begin
                    state_d = IDLE;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tmo_d   = '0;
            end
        endcase
    end

    // Slave mux and response routing; ack beats a simultaneous timeout.
    always_comb begin
        slv_stb   = 1'b0;
        slv_we    = 1'b0;
        slv_addr  = '0;
        slv_wdata = '0;
        slv_sel   = '0;
        m0_rdata  = '0;
        m0_ack    = 1'b0;
        m0_err    = 1'b0;
        m1_rdata  = '0;
        m1_ack    = 1'b0;
        m1_err    = 1'b0;
        case (state_q)
            GNT0: begin
                slv_stb  = 1'b1;
                slv_addr = m0_addr;
                slv_sel  = {SEL_W{1'b1}};
                m0_rdata = slv_rdata;
                m0_ack   = slv_ack;
                m0_err   = !slv_ack && tmo_hit;
            end
            GNT1: begin
                slv_stb   = 1'b1;
                slv_we    = m1_we;
                slv_addr  = m1_addr;
                slv_wdata = m1_wdata;
                slv_sel   = m1_sel;
                m1_rdata  = slv_rdata;
                m1_ack    = slv_ack;
                m1_err    = !slv_ack && tmo_hit;
            end
            default: begin
            end
        endcase
    end

    assign stall_if  = m0_req & ~m0_ack & ~m0_err;
    assign stall_mem = m1_req & ~m1_ack & ~m1_err;

endmodule
